layer_pool2d_stream: RTL and testbench
======================================

// Module: layer_pool2d_stream
// PURPOSE
// - Streaming successor to the combinational max-pool layer: one window element per beat for all
//   FILTER_IN channels, reduced over KSIZE beats; result delivered on a registered output.
// - Runtime mode: MAX or AVG (arithmetic mean). Valid/ready on both sides for layer chaining.
// - Sits between a conv layer and the next layer, replacing the wide all-elements-at-once input bus.
// PARAMETERS
// - FILTER_IN  32         channel count, processed in parallel
// - KSIZE      4          window elements per output; power of 2, >= 2
// - DATA_W     `BIT_DATA  signed width of each channel sample
// PORTS
// - clock      in   1                  single clock, all logic on rising edge
// - reset      in   1                  synchronous, active-high
// - mode       in   1                  0 = MAX, 1 = AVG; sampled on first beat of a window
// - abort      in   1                  discard the partial window (synchronous)
// - in_valid   in   1                  x carries a valid window element
// - in_ready   out  1                  beat accepted when in_valid && in_ready
// - x          in   FILTER_IN*DATA_W   channel i at x[DATA_W*(i+1)-1 : DATA_W*i]
// - out_valid  out  1                  y holds a completed window result
// - out_ready  in   1                  consumer accepts y when out_valid && out_ready
// - y          out  FILTER_IN*DATA_W   per-channel result, same packing as x
// BEHAVIOUR
// - Reset: beat counter 0, accumulators 0, mode latch 0, out_valid 0, y 0. Reset mid-window drops
//   the partial window and any undelivered result.
// - Beat counter cnt: 0..KSIZE-1. Accepted beat increments it; wraps to 0 on the KSIZE-th beat.
// - First beat (cnt==0): acc[i] <= x[i] (no init value); latch mode. Mode changes mid-window ignored.
// - Later beats: MAX: acc[i] <= max(acc[i], x[i]), signed compare.
//   AVG: acc[i] <= acc[i] + x[i], sign-extended.
// - acc width DATA_W + log2(KSIZE); no overflow possible.
// - Last beat (cnt==KSIZE-1): the final reduction including the current x is written to y;
//   out_valid <= 1 on the next edge.
//   Latency is 1 cycle from last beat to out_valid; throughput is 1 beat/cycle sustained.
// - AVG result: (sum >>> log2(KSIZE)), arithmetic shift (floor toward -inf), low DATA_W bits.
//   MAX result: acc low DATA_W bits.
// - y and out_valid hold stable while out_valid && !out_ready.
//   out_valid clears on handshake unless a new result loads in the same cycle.
// - in_ready = !(cnt==KSIZE-1 && out_valid && !out_ready). Beats 0..KSIZE-2 of the next window
//   are always accepted under backpressure; only the completing beat stalls.
// - Simultaneous out handshake and completing beat: y reloads, out_valid stays 1, no bubble.
// - abort: cnt <= 0, the beat offered in that cycle is not consumed and in_ready is forced 0.
//   abort has priority over a completing beat. It does not affect out_valid or y.
// - in_valid low: state holds. The x value is ignored when no handshake occurs.
// TESTING  (FILTER_IN=2, KSIZE=4, DATA_W=8 unless stated)
// - MAX: ch0 3,-5,7,1 and ch1 -128,-128,-1,-128 back-to-back -> 1 cycle after beat 4:
//   out_valid=1, y ch0=7, ch1=-1.
// - AVG: ch0 3,5,7,1 and ch1 -1,-2,-1,-1 -> y ch0=4, ch1=-2 (floor of -1.25). Edge case:
//   ch0 127 x4 -> 127; ch0 -128 x4 -> -128.
// - Backpressure: out_ready=0 with a result pending, stream 4 more beats -> beats 1-3 accepted,
//   beat 4 stalls (in_ready=0), y unchanged. Raise out_ready -> beat 4 accepted in that cycle,
//   new y next cycle, out_valid never drops.
// - Mode latch: mode=0 on beat 1, mode=1 on beats 2-4 with ch0 3,5,7,1 -> y ch0=7 (MAX).
// - abort after 2 beats, then 4 fresh beats 1,1,1,1 in AVG -> y=1. No output is produced for the
//   aborted window. abort coinciding with beat 4 -> no out_valid.
// - reset asserted after beat 2 and released -> out_valid=0, y=0. The next 4 beats form a
//   complete new window.

Source files
------------

// File: rtl/layer_pool2d_stream.sv
// Streaming 2D pooling layer: one window element per beat for all channels, MAX or AVG
// reduction over KSIZE beats, registered result with valid/ready on both sides.
`ifndef BIT_DATA
`define BIT_DATA 8
`endif

module pool_lane #(
  parameter int DATA_W = 8,
  parameter int SH     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_fire,
  input  logic              i_first,
  input  logic              i_last,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_x,
  output logic [DATA_W-1:0] o_y
);
  localparam int AW = DATA_W + SH;

  logic signed [AW-1:0] r_acc, w_xe, w_red;
  logic [DATA_W-1:0]    r_y, w_avg, w_max;

  assign w_xe = {{SH{i_x[DATA_W-1]}}, i_x};

  // First beat seeds the accumulator; later beats fold x in with the latched mode.
  always_comb begin
    w_red = w_xe;
    if (!i_first) begin
      if (i_mode)              w_red = r_acc + w_xe;
      else if (w_xe > r_acc)   w_red = w_xe;
      else                     w_red = r_acc;
    end
  end

  assign w_avg = DATA_W'(w_red >>> SH);
  assign w_max = DATA_W'(w_red);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= '0;
      r_y   <= '0;
    end else begin
      if (i_fire) r_acc <= w_red;
      if (i_last) r_y   <= i_mode ? w_avg : w_max;
    end
  end

  assign o_y = r_y;
endmodule

module layer_pool2d_stream #(
  parameter int FILTER_IN = 32,
  parameter int KSIZE     = 4,
  parameter int DATA_W    = `BIT_DATA
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        abort,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FILTER_IN*DATA_W-1:0] x,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FILTER_IN*DATA_W-1:0] y
);
  localparam int SH = $clog2(KSIZE);
  localparam int CW = SH;

  logic [CW-1:0] r_cnt;
  logic          r_mode, r_out_valid;
  logic          w_cnt_last, w_fire, w_first, w_last;

  assign w_cnt_last = (r_cnt == CW'(KSIZE-1));
  // Only the completing beat waits on the consumer; earlier beats only touch acc.
  assign in_ready   = !abort && !(w_cnt_last && r_out_valid && !out_ready);
  assign w_fire     = in_valid && in_ready;
  assign w_first    = w_fire && (r_cnt == '0);
  assign w_last     = w_fire && w_cnt_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (abort)       r_cnt <= '0;
      else if (w_fire) r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
      if (w_first) r_mode <= mode;
      if (w_last)         r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;

  for (genvar g = 0; g < FILTER_IN; g++) begin : g_lane
    pool_lane #(.DATA_W(DATA_W), .SH(SH)) u_lane (
      .clock   (clock),
      .reset   (reset),
      .i_fire  (w_fire),
      .i_first (w_first),
      .i_last  (w_last),
      .i_mode  (r_mode),
      .i_x     (x[DATA_W*g +: DATA_W]),
      .o_y     (y[DATA_W*g +: DATA_W])
    );
  end
endmodule

// File: tb/tb_layer_pool2d_stream.sv
// Directed bench for layer_pool2d_stream: 2 channels, 4-beat windows, 8-bit samples.
module tb_layer_pool2d_stream;
  logic        clock = 1'b0;
  logic        reset, mode, abort, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] x, y;
  int          n_chk = 0, n_pass = 0;

  layer_pool2d_stream #(.FILTER_IN(2), .KSIZE(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .mode(mode), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic m);
    mode = m; x = {b, a}; in_valid = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; abort = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0;
    repeat (2) @(posedge clock); #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_y", y, 0);
    reset = 1'b0;
    chk("rst_rdy", in_ready, 1);

    // MAX
    beat(8'd3, 8'h80, 0); beat(8'hFB, 8'h80, 0); beat(8'd7, 8'hFF, 0);
    chk("max_pre_vld", out_valid, 0);
    beat(8'd1, 8'h80, 0);
    chk("max_vld", out_valid, 1);
    chk("max_ch0", y[7:0], 8'd7);
    chk("max_ch1", y[15:8], 8'hFF);
    idle();
    chk("max_drain", out_valid, 0);

    // AVG with floor toward -inf
    beat(8'd3, 8'hFF, 1); beat(8'd5, 8'hFE, 1); beat(8'd7, 8'hFF, 1); beat(8'd1, 8'hFF, 1);
    chk("avg_vld", out_valid, 1);
    chk("avg_ch0", y[7:0], 8'd4);
    chk("avg_ch1", y[15:8], 8'hFE);
    // AVG extremes
    repeat (4) beat(8'd127, 8'h80, 1);
    chk("avg_max_ch0", y[7:0], 8'd127);
    chk("avg_min_ch1", y[15:8], 8'h80);
    idle();

    // Backpressure
    out_ready = 1'b0;
    beat(8'd1, 8'd0, 0); beat(8'd2, 8'd0, 0); beat(8'd3, 8'd0, 0); beat(8'd4, 8'd0, 0);
    chk("bp_y0", y[7:0], 8'd4);
    mode = 0; x = {8'd0, 8'd10}; in_valid = 1'b1; #1;
    chk("bp_rdy1", in_ready, 1);
    @(posedge clock); #1;
    x = {8'd0, 8'd20}; #1; chk("bp_rdy2", in_ready, 1);
    @(posedge clock); #1;
    x = {8'd0, 8'd30}; #1; chk("bp_rdy3", in_ready, 1);
    @(posedge clock); #1;
    x = {8'd0, 8'd40}; #1; chk("bp_stall", in_ready, 0);
    @(posedge clock); #1;
    chk("bp_hold_y", y[7:0], 8'd4);
    chk("bp_hold_vld", out_valid, 1);
    out_ready = 1'b1; #1;
    chk("bp_release", in_ready, 1);
    @(posedge clock); #1;
    chk("bp_new_vld", out_valid, 1);
    chk("bp_new_y", y[7:0], 8'd40);
    idle();
    chk("bp_drain", out_valid, 0);

    // Mode latched on first beat
    beat(8'd3, 8'd0, 0); beat(8'd5, 8'd0, 1); beat(8'd7, 8'd0, 1); beat(8'd1, 8'd0, 1);
    chk("latch_y", y[7:0], 8'd7);
    idle();

    // Abort after 2 beats, fresh AVG window
    beat(8'd5, 8'd5, 1); beat(8'd5, 8'd5, 1);
    abort = 1'b1; x = 16'h0909; #1;
    chk("abort_rdy", in_ready, 0);
    @(posedge clock); #1;
    abort = 1'b0;
    beat(8'd1, 8'd1, 1); beat(8'd1, 8'd1, 1); beat(8'd1, 8'd1, 1);
    chk("abort_novld", out_valid, 0);
    beat(8'd1, 8'd1, 1);
    chk("abort_vld", out_valid, 1);
    chk("abort_y", y, 16'h0101);
    idle();

    // Abort coinciding with completing beat
    beat(8'd2, 8'd2, 1); beat(8'd2, 8'd2, 1); beat(8'd2, 8'd2, 1);
    abort = 1'b1; x = 16'h3030;
    @(posedge clock); #1;
    chk("abort_last_vld", out_valid, 0);
    abort = 1'b0;
    beat(8'd6, 8'd6, 1); beat(8'd6, 8'd6, 1); beat(8'd6, 8'd6, 1);
    chk("abort_last_cnt", out_valid, 0);
    beat(8'd6, 8'd6, 1);
    chk("abort_last_y", y, 16'h0606);
    idle();

    // Reset mid-window
    beat(8'd9, 8'd9, 0); beat(8'd9, 8'd9, 0);
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_y", y, 0);
    beat(8'd8, 8'hFD, 0); beat(8'd8, 8'hFD, 0); beat(8'd8, 8'hFD, 0);
    chk("mrst_pre", out_valid, 0);
    beat(8'd8, 8'hFD, 0);
    chk("mrst_vld2", out_valid, 1);
    chk("mrst_y2", y, 16'hFD08);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
